// File: rtl/furv_dbus_bridge.sv
// furv data-port to Wishbone-classic master bridge: registers the core request, returns data and a one-cycle ack.
// Optional bus timeout is enabled by defining FURV_DBUS_TIMEOUT_EN.
module furv_dbus_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        core_mem,
   input  logic        core_we,
   input  logic [29:0] core_addr,
   input  logic [3:0]  core_sel,
   input  logic [31:0] core_wdata,
   output logic [31:0] core_rdata,
   output logic        core_ack,
   output logic        wb_cyc,
   output logic        wb_stb,
   output logic        wb_we,
   output logic [29:0] wb_adr,
   output logic [3:0]  wb_sel,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack,
   input  logic        wb_err,
   output logic        bus_error,
   input  logic        err_clr
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        cyc_q, cyc_d;
   logic        we_q, we_d;
   logic [29:0] adr_q, adr_d;
   logic [3:0]  sel_q, sel_d;
   logic [31:0] dat_q, dat_d;
   logic [31:0] rdata_q, rdata_d;
   logic        ack_q, ack_d;
   logic        berr_q, berr_d;
   logic        expired;

`ifdef FURV_DBUS_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   // Expiry is flagged on the last permitted BUS cycle so wb_cyc is high exactly TIMEOUT_CYCLES cycles.
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE && core_mem) begin
         cnt_d = '0;
      end else if (state_q == BUS && !wb_ack && !wb_err && !expired) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   assign expired = (state_q == BUS) && (cnt_q == CNT_LAST);
`else
   assign expired = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cyc_q   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= '0;
         sel_q   <= '0;
         dat_q   <= '0;
         rdata_q <= '0;
         ack_q   <= 1'b0;
         berr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         sel_q   <= sel_d;
         dat_q   <= dat_d;
         rdata_q <= rdata_d;
         ack_q   <= ack_d;
         berr_q  <= berr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      we_d    = we_q;
      adr_d   = adr_q;
      sel_d   = sel_q;
      dat_d   = dat_q;
      rdata_d = rdata_q;
      ack_d   = 1'b0;
      // A termination in the same cycle as err_clr overrides the clear below.
      berr_d  = err_clr ? 1'b0 : berr_q;

      unique case (state_q)
         IDLE: begin
            if (core_mem) begin
               we_d    = core_we;
               adr_d   = core_addr;
               sel_d   = core_sel;
               dat_d   = core_wdata;
               cyc_d   = 1'b1;
               state_d = BUS;
            end
         end
         BUS: begin
            if (wb_err || (expired && !wb_ack)) begin
               cyc_d   = 1'b0;
               berr_d  = 1'b1;
               ack_d   = 1'b1;
               state_d = DONE;
               if (!we_q) begin
                  rdata_d = ERR_RDATA;
               end
            end else if (wb_ack) begin
               cyc_d   = 1'b0;
               ack_d   = 1'b1;
               state_d = DONE;
               if (!we_q) begin
                  rdata_d = wb_dat_i;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cyc_d   = 1'b0;
         end
      endcase
   end

   assign wb_cyc     = cyc_q;
   assign wb_stb     = cyc_q;
   assign wb_we      = we_q;
   assign wb_adr     = adr_q;
   assign wb_sel     = sel_q;
   assign wb_dat_o   = dat_q;
   assign core_rdata = rdata_q;
   assign core_ack   = ack_q;
   assign bus_error  = berr_q;

endmodule
